// File: rtl/prefix_fuser.sv
// prefix_fuser
//   Collects optional T and I prefix words in front of a base instruction
//   and emits one fused bundle per base word through a registered
//   valid/ready output stage.
//
//   Parameter MAX_GAP (1..255): the number of idle cycles a pending prefix
//   may wait for its base word before it is dropped as stale.
//
//   Optional feature macro PREFIX_FUSER_STATS_EN: when defined, fused_cnt
//   counts transferred bundles that carry a prefix, saturating at 16'hFFFF.
//   When it is undefined, fused_cnt is tied to zero.
//
//   Ports
//     clk, rst_n           clock, asynchronous active-low reset
//     in_valid, in_instr   fetched word (opcode in [31:29])
//     in_ready             word is accepted when in_valid && in_ready
//     flush                drop pending prefixes, the output bundle and the
//                          input word of this cycle
//     out_valid, out_ready bundle handshake
//     out_instr            base word
//     out_has_t, out_ta3, out_tt3, out_ta4, out_tt4   T prefix fields
//     out_has_i, out_immhi                            I prefix fields
//     err_dup              pulse: same-type prefix overwrote a pending one
//     err_stale            pulse: pending prefixes dropped by timeout
//     fused_cnt            transferred bundles that had a prefix
module prefix_fuser #(
  parameter int MAX_GAP = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_has_t,
  output logic [5:0]  out_ta3,
  output logic [5:0]  out_ta4,
  output logic [1:0]  out_tt3,
  output logic [1:0]  out_tt4,
  output logic        out_has_i,
  output logic [25:0] out_immhi,
  output logic        err_dup,
  output logic        err_stale,
  output logic [15:0] fused_cnt
);

  localparam logic [7:0] GAP_LIMIT = 8'(MAX_GAP);
  localparam logic [2:0] OP_T      = 3'b011;
  localparam logic [2:0] OP_I      = 3'b100;

  typedef enum logic {IDLE, PEND} state_t;

  state_t      state_reg, state_next;
  logic        t_pend_reg, i_pend_reg;
  logic [15:0] t_word_reg;
  logic [25:0] immhi_reg;
  logic [7:0]  gap_reg;

  logic        out_valid_reg, out_has_t_reg, out_has_i_reg;
  logic [31:0] out_instr_reg;
  logic [15:0] out_t_reg;
  logic [25:0] out_immhi_reg;
  logic        err_dup_reg, err_stale_reg;

  logic accept, is_t, is_i, is_base;
  logic t_acc, i_acc, base_acc, timeout;

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;
  assign is_t     = (in_instr[31:29] == OP_T);
  assign is_i     = (in_instr[31:29] == OP_I);
  assign is_base  = !is_t && !is_i;

  // Flush swallows the input word, so every accept-driven action is gated by it.
  assign t_acc    = accept && is_t && !flush;
  assign i_acc    = accept && is_i && !flush;
  assign base_acc = accept && is_base && !flush;

  // Any accept restarts the gap, so a base word arriving exactly at the
  // limit still fuses instead of timing out.
  assign timeout  = (state_reg == PEND) && (gap_reg == GAP_LIMIT) && !accept && !flush;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (t_acc || i_acc) state_next = PEND;
      PEND:    if (flush || base_acc || timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pending prefixes and gap counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_pend_reg <= 1'b0;
      i_pend_reg <= 1'b0;
      t_word_reg <= 16'h0000;
      immhi_reg  <= 26'h0;
      gap_reg    <= 8'h00;
    end else if (flush) begin
      t_pend_reg <= 1'b0;
      i_pend_reg <= 1'b0;
      gap_reg    <= 8'h00;
    end else if (accept) begin
      gap_reg <= 8'h00;
      if (is_t) begin
        t_pend_reg <= 1'b1;
        t_word_reg <= in_instr[15:0];
      end else if (is_i) begin
        i_pend_reg <= 1'b1;
        immhi_reg  <= in_instr[25:0];
      end else begin
        t_pend_reg <= 1'b0;
        i_pend_reg <= 1'b0;
      end
    end else if (timeout) begin
      t_pend_reg <= 1'b0;
      i_pend_reg <= 1'b0;
      gap_reg    <= 8'h00;
    end else if (state_reg == PEND) begin
      gap_reg <= gap_reg + 8'd1;
    end
  end

  // Error pulses, registered so they appear the cycle after the event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_dup_reg   <= 1'b0;
      err_stale_reg <= 1'b0;
    end else begin
      err_dup_reg   <= (t_acc && t_pend_reg) || (i_acc && i_pend_reg);
      err_stale_reg <= timeout;
    end
  end

  // Output bundle register; prefix fields are masked to zero when absent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_instr_reg <= 32'h0;
      out_has_t_reg <= 1'b0;
      out_t_reg     <= 16'h0;
      out_has_i_reg <= 1'b0;
      out_immhi_reg <= 26'h0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
      out_instr_reg <= 32'h0;
      out_has_t_reg <= 1'b0;
      out_t_reg     <= 16'h0;
      out_has_i_reg <= 1'b0;
      out_immhi_reg <= 26'h0;
    end else if (base_acc) begin
      out_valid_reg <= 1'b1;
      out_instr_reg <= in_instr;
      out_has_t_reg <= t_pend_reg;
      out_t_reg     <= t_pend_reg ? t_word_reg : 16'h0;
      out_has_i_reg <= i_pend_reg;
      out_immhi_reg <= i_pend_reg ? immhi_reg : 26'h0;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_instr = out_instr_reg;
  assign out_has_t = out_has_t_reg;
  assign out_ta3   = out_t_reg[5:0];
  assign out_tt3   = out_t_reg[7:6];
  assign out_ta4   = out_t_reg[13:8];
  assign out_tt4   = out_t_reg[15:14];
  assign out_has_i = out_has_i_reg;
  assign out_immhi = out_immhi_reg;
  assign err_dup   = err_dup_reg;
  assign err_stale = err_stale_reg;

`ifdef PREFIX_FUSER_STATS_EN
  logic [15:0] fused_cnt_reg;

  // Counts on the transfer handshake, so a flush does not clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fused_cnt_reg <= 16'h0000;
    end else if (out_valid_reg && out_ready && (out_has_t_reg || out_has_i_reg)
                 && (fused_cnt_reg != 16'hFFFF)) begin
      fused_cnt_reg <= fused_cnt_reg + 16'd1;
    end
  end

  assign fused_cnt = fused_cnt_reg;
`else
  assign fused_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_prefix_fuser.sv
// tb_prefix_fuser
//   Directed bench for prefix_fuser: a table of prefix/base sequences with
//   hand-computed bundles, followed by hand-written sequences for duplicate
//   prefixes, stale timeout, backpressure, flush, reset and statistics.
module tb_prefix_fuser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_has_t;
  logic [5:0]  out_ta3, out_ta4;
  logic [1:0]  out_tt3, out_tt4;
  logic        out_has_i;
  logic [25:0] out_immhi;
  logic        err_dup, err_stale;
  logic [15:0] fused_cnt;

  int checks = 0;
  int errors = 0;

  prefix_fuser #(.MAX_GAP(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_has_t(out_has_t), .out_ta3(out_ta3), .out_ta4(out_ta4),
    .out_tt3(out_tt3), .out_tt4(out_tt4),
    .out_has_i(out_has_i), .out_immhi(out_immhi),
    .err_dup(err_dup), .err_stale(err_stale), .fused_cnt(fused_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        t_en;
    logic [31:0] t_word;
    logic        i_en;
    logic [31:0] i_word;
    logic        i_first;
    logic [31:0] base;
    logic        has_t;
    logic [5:0]  ta3;
    logic [1:0]  tt3;
    logic [5:0]  ta4;
    logic [1:0]  tt4;
    logic        has_i;
    logic [25:0] immhi;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("chk %s ok value=%0h", name, act);
    end
  endtask

  task automatic send(input logic [31:0] word);
    in_valid = 1'b1;
    in_instr = word;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_instr = 32'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [75:0] bundle_act();
    return {out_instr, out_has_t, out_tt4, out_ta4, out_tt3, out_ta3, out_has_i, out_immhi};
  endfunction

  int stale_cnt;
  int stale_at;
  logic [15:0] exp_cnt;

  initial begin
    vecs[0] = '{1'b1, 32'h6000_C2C5, 1'b1, 32'h8123_4567, 1'b0, 32'h0400_0001,
                1'b1, 6'd5, 2'd3, 6'd2, 2'd3, 1'b1, 26'h123_4567};
    vecs[1] = '{1'b1, 32'h7FFF_FFFF, 1'b0, 32'h0, 1'b0, 32'h2000_0000,
                1'b1, 6'h3F, 2'd3, 6'h3F, 2'd3, 1'b0, 26'h0};
    vecs[2] = '{1'b0, 32'h0, 1'b1, 32'h9FFF_FFFF, 1'b0, 32'hE000_0005,
                1'b0, 6'd0, 2'd0, 6'd0, 2'd0, 1'b1, 26'h3FF_FFFF};
    vecs[3] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0000_0000,
                1'b0, 6'd0, 2'd0, 6'd0, 2'd0, 1'b0, 26'h0};
    vecs[4] = '{1'b1, 32'h6000_4140, 1'b1, 32'h8000_00AA, 1'b1, 32'hA000_1234,
                1'b1, 6'd0, 2'd1, 6'd1, 2'd1, 1'b1, 26'h0AA};
    vecs[5] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'hFFFF_FFFF,
                1'b0, 6'd0, 2'd0, 6'd0, 2'd0, 1'b0, 26'h0};

    rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'h0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 128'(out_valid), 128'(1'b0));
    chk("reset_bundle", 128'(bundle_act()), 128'(76'h0));
    chk("reset_errs", 128'({err_dup, err_stale}), 128'(2'b00));
    chk("reset_fused_cnt", 128'(fused_cnt), 128'(16'h0));
    chk("reset_in_ready", 128'(in_ready), 128'(1'b1));
    rst_n = 1'b1;
    idle(1);

    // Table of prefix/base sequences
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].i_first) begin
        if (vecs[i].i_en) send(vecs[i].i_word);
        if (vecs[i].t_en) send(vecs[i].t_word);
      end else begin
        if (vecs[i].t_en) send(vecs[i].t_word);
        if (vecs[i].i_en) send(vecs[i].i_word);
      end
      send(vecs[i].base);
      chk($sformatf("vec%0d_valid", i), 128'(out_valid), 128'(1'b1));
      chk($sformatf("vec%0d_bundle", i), 128'(bundle_act()),
          128'({vecs[i].base, vecs[i].has_t, vecs[i].tt4, vecs[i].ta4,
                vecs[i].tt3, vecs[i].ta3, vecs[i].has_i, vecs[i].immhi}));
    end
    idle(1);
    chk("drain_valid", 128'(out_valid), 128'(1'b0));

    // Duplicate T prefix
    send(32'h6000_0001);
    chk("dup_first_none", 128'(err_dup), 128'(1'b0));
    send(32'h6000_0002);
    chk("dup_pulse", 128'(err_dup), 128'(1'b1));
    idle(1);
    chk("dup_one_cycle", 128'(err_dup), 128'(1'b0));
    send(32'h0000_0010);
    chk("dup_bundle", 128'({out_valid, out_has_t, out_ta3, out_tt3, out_ta4, out_tt4}),
        128'({1'b1, 1'b1, 6'd2, 2'd0, 6'd0, 2'd0}));

    // Stale I prefix: gap reaches 15 after 15 idle edges, drop on the 16th
    send(32'h8000_0001);
    stale_cnt = 0; stale_at = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (err_stale) begin
        stale_cnt++;
        if (stale_at == 0) stale_at = k;
      end
    end
    chk("stale_count", 128'(stale_cnt), 128'(1));
    chk("stale_cycle", 128'(stale_at), 128'(16));
    send(32'h0000_0020);
    chk("stale_base_no_i", 128'({out_valid, out_has_i, out_immhi}), 128'({1'b1, 1'b0, 26'h0}));

    // Base word in the very cycle the gap hits the limit still fuses
    send(32'h8000_0002);
    idle(15);
    send(32'h0000_0030);
    chk("limit_fuse", 128'({out_valid, out_has_i, out_immhi}), 128'({1'b1, 1'b1, 26'h2}));
    chk("limit_no_stale", 128'(err_stale), 128'(1'b0));
    idle(2);
    chk("limit_no_stale_after", 128'(err_stale), 128'(1'b0));

    // Backpressure: bundle A held while B waits
    out_ready = 1'b0;
    send(32'h0000_00A1);
    chk("bp_a_valid", 128'(out_valid), 128'(1'b1));
    chk("bp_in_ready_low", 128'(in_ready), 128'(1'b0));
    in_valid = 1'b1; in_instr = 32'h0000_00B2;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", k), 128'({out_valid, in_ready, out_instr}),
          128'({1'b1, 1'b0, 32'h0000_00A1}));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", 128'(in_ready), 128'(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0; in_instr = 32'h0;
    chk("bp_b_out", 128'({out_valid, out_instr}), 128'({1'b1, 32'h0000_00B2}));
    idle(1);
    chk("bp_drain", 128'(out_valid), 128'(1'b0));

    // Flush together with a base accept while a prefix is pending
    send(32'h6000_0003);
    in_valid = 1'b1; in_instr = 32'h0000_0040; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_instr = 32'h0; flush = 1'b0;
    chk("flush_no_bundle", 128'(out_valid), 128'(1'b0));
    chk("flush_no_err", 128'({err_dup, err_stale}), 128'(2'b00));
    stale_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (err_stale) stale_cnt++;
    end
    chk("flush_cleared_pend", 128'(stale_cnt), 128'(0));
    send(32'h0000_0050);
    chk("flush_next_plain", 128'({out_valid, out_has_t}), 128'({1'b1, 1'b0}));

    // Flush drops a held bundle
    out_ready = 1'b0;
    idle(1);
    chk("flush_held_valid", 128'(out_valid), 128'(1'b1));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_held_dropped", 128'(out_valid), 128'(1'b0));

    // Asynchronous reset with a held bundle
    send(32'h0000_0070);
    chk("rst_pre_valid", 128'(out_valid), 128'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_clear", 128'({out_valid, out_instr}), 128'({1'b0, 32'h0}));
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Reset in the middle of a pending prefix
    send(32'h6000_0005);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    send(32'h0000_0080);
    chk("rst_prefix_dropped", 128'({out_valid, out_has_t, out_ta3}), 128'({1'b1, 1'b0, 6'd0}));
    idle(1);
    chk("rst_fused_cnt_zero", 128'(fused_cnt), 128'(16'h0));

    // Statistics: 3 prefixed bundles and 2 plain ones
    send(32'h6000_0001); send(32'h0000_0001);
    send(32'h8000_0001); send(32'h0000_0002);
    send(32'h6000_0001); send(32'h8000_0002); send(32'h0000_0003);
    send(32'h0000_0004);
    send(32'h0000_0005);
    idle(2);
`ifdef PREFIX_FUSER_STATS_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif
    chk("fused_cnt", 128'(fused_cnt), 128'(exp_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
